lcd_bus_reader: RTL and testbench

LCD_BUS_READER -- requirements
Module: lcd_bus_reader

---
 rtl/lcd_bus_reader.sv | 158 +++++++++++++++
 tb/tb_lcd_bus_reader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_reader.sv
// HD44780-style LCD read sequencer: drives RS/RW/EN with programmable setup,
// pulse, hold and gap timing, with optional busy-flag polling on status reads.
module lcd_bus_reader #(
  parameter int SETUP_CYC = 3,
  parameter int EN_CYC    = 13,
  parameter int HOLD_CYC  = 3,
  parameter int GAP_CYC   = 25,
  parameter int MAX_POLLS = 255
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rd_req_i,
  input  logic       rd_rs_i,
  input  logic       wait_bf_i,
  output logic       rd_ready_o,
  output logic       rd_valid_o,
  output logic [7:0] rd_data_o,
  output logic       busy_o,
  output logic [6:0] addr_o,
  output logic       timeout_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_en_o,
  input  logic [7:0] lcd_data_in_i,
  output logic       lcd_data_oe_o
);

  typedef enum logic [2:0] {IDLE, SETUP, EN_HIGH, HOLD, GAP, DONE} state_t;

  state_t     state_q;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] polls_q, polls_d;
  logic       rs_q, waitBf_q;
  logic [7:0] data_q;
  logic       busy_q, timeout_q;
  logic [6:0] addr_q;
  logic       lcdRs_q, lcdRw_q, lcdEn_q, lcdOe_q;
  logic       rdReady_q, rdValid_q;
  logic       lastCyc;

  // Per-state dwell counter end detect; poll counter saturates instead of wrapping.
  always_comb begin
    cnt_d   = cnt_q + 8'd1;
    polls_d = (polls_q == 8'(MAX_POLLS)) ? polls_q : polls_q + 8'd1;
    lastCyc = 1'b0;
    case (state_q)
      SETUP:   lastCyc = (cnt_q == 8'(SETUP_CYC - 1));
      EN_HIGH: lastCyc = (cnt_q == 8'(EN_CYC - 1));
      HOLD:    lastCyc = (cnt_q == 8'(HOLD_CYC - 1));
      GAP:     lastCyc = (cnt_q == 8'(GAP_CYC - 1));
      default: lastCyc = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      polls_q   <= 8'd0;
      rs_q      <= 1'b0;
      waitBf_q  <= 1'b0;
      data_q    <= 8'd0;
      busy_q    <= 1'b1;
      addr_q    <= 7'd0;
      timeout_q <= 1'b0;
      lcdRs_q   <= 1'b0;
      lcdRw_q   <= 1'b0;
      lcdEn_q   <= 1'b0;
      lcdOe_q   <= 1'b1;
      rdReady_q <= 1'b1;
      rdValid_q <= 1'b0;
    end else begin
      rdValid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rd_req_i) begin
            rs_q      <= rd_rs_i;
            waitBf_q  <= wait_bf_i & ~rd_rs_i;
            lcdRs_q   <= rd_rs_i;
            lcdRw_q   <= 1'b1;
            lcdOe_q   <= 1'b0;
            cnt_q     <= 8'd0;
            polls_q   <= 8'd0;
            rdReady_q <= 1'b0;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          if (lastCyc) begin
            lcdEn_q <= 1'b1;
            cnt_q   <= 8'd0;
            state_q <= EN_HIGH;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        // The bus is captured on the same edge that drops EN.
        EN_HIGH: begin
          if (lastCyc) begin
            lcdEn_q <= 1'b0;
            data_q  <= lcd_data_in_i;
            polls_q <= polls_d;
            cnt_q   <= 8'd0;
            state_q <= HOLD;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        HOLD: begin
          if (lastCyc) begin
            cnt_q   <= 8'd0;
            lcdRw_q <= 1'b0;
            if (waitBf_q && data_q[7] && (polls_q < 8'(MAX_POLLS))) begin
              state_q <= GAP;
            end else begin
              rdValid_q <= 1'b1;
              state_q   <= DONE;
              if (!rs_q) begin
                busy_q    <= data_q[7];
                addr_q    <= data_q[6:0];
                timeout_q <= waitBf_q & data_q[7];
              end
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        GAP: begin
          if (lastCyc) begin
            cnt_q   <= 8'd0;
            lcdRw_q <= 1'b1;
            state_q <= SETUP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE: begin
          lcdOe_q   <= 1'b1;
          rdReady_q <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_ready_o    = rdReady_q;
  assign rd_valid_o    = rdValid_q;
  assign rd_data_o     = data_q;
  assign busy_o        = busy_q;
  assign addr_o        = addr_q;
  assign timeout_o     = timeout_q;
  assign lcd_rs_o      = lcdRs_q;
  assign lcd_rw_o      = lcdRw_q;
  assign lcd_en_o      = lcdEn_q;
  assign lcd_data_oe_o = lcdOe_q;

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Bench for lcd_bus_reader: vector table through a scoreboard, an LCD bus
// responder, a timing/protocol monitor and hand-written reset/abort sequences.
module tb_lcd_bus_reader;

  logic       clk = 1'b0;
  logic       reset, rdReq, rdRs, waitBf;
  logic       rdReady, rdValid, busy, timeout;
  logic [7:0] rdData;
  logic [6:0] addr;
  logic       lcdRs, lcdRw, lcdEn, lcdOe;
  logic [7:0] lcdDataIn;

  lcd_bus_reader #(
    .SETUP_CYC(3), .EN_CYC(13), .HOLD_CYC(3), .GAP_CYC(25), .MAX_POLLS(4)
  ) dut (
    .clk_i(clk), .reset_i(reset), .rd_req_i(rdReq), .rd_rs_i(rdRs),
    .wait_bf_i(waitBf), .rd_ready_o(rdReady), .rd_valid_o(rdValid),
    .rd_data_o(rdData), .busy_o(busy), .addr_o(addr), .timeout_o(timeout),
    .lcd_rs_o(lcdRs), .lcd_rw_o(lcdRw), .lcd_en_o(lcdEn),
    .lcd_data_in_i(lcdDataIn), .lcd_data_oe_o(lcdOe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       rs;
    logic       wbf;
    int         busyReads;
    logic [7:0] busyByte;
    logic [7:0] finalByte;
    logic       stray;
    logic [7:0] expData;
    logic       expBusy;
    logic [6:0] expAddr;
    logic       expTo;
    int         expPulses;
    int         expLat;
  } vec_t;

  vec_t vecs[8];
  vec_t expQ[$];
  vec_t expHead;

  int passCnt = 0, totalCnt = 0, protoErr = 0;
  int acceptK = -10, pulses = 0, enHigh = 0, lastHighCyc = 0;
  logic enPrev = 1'b0, validPrev = 1'b0, inAbort = 1'b0;
  logic curRs = 1'b0;
  int curBusyReads = 0;
  logic [7:0] curBusyByte = 8'h00, curFinal = 8'h00;

  // LCD responder: the first busyReads pulses return the busy byte.
  assign lcdDataIn = (pulses < curBusyReads) ? curBusyByte : curFinal;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: protocol rules, EN timing, and scoreboard pop on rd_valid.
  always @(negedge clk) begin
    if (lcdEn && !lcdRw) protoErr++;
    if (lcdOe && lcdRw) protoErr++;
    if (!reset && rdReq && rdReady) begin
      acceptK = cyc;
      pulses  = 0;
      enHigh  = 0;
    end
    if (!inAbort && cyc == acceptK + 1) begin
      checkOutput("rw_after_accept", lcdRw, 1);
      checkOutput("rs_after_accept", lcdRs, curRs);
      checkOutput("oe_after_accept", lcdOe, 0);
    end
    if (inAbort || reset) begin
      enHigh = 0;
    end else begin
      if (lcdEn && !enPrev) begin
        if (pulses == 0) checkOutput("first_en_offset", cyc - acceptK, 4);
        else checkOutput("en_gap", cyc - lastHighCyc - 1, 31);
      end
      if (lcdEn) begin
        enHigh++;
        lastHighCyc = cyc;
      end else if (enPrev) begin
        checkOutput("en_width", enHigh, 13);
        enHigh = 0;
        pulses++;
      end
    end
    enPrev = lcdEn;
    if (validPrev) begin
      checkOutput("valid_one_cycle", rdValid, 0);
      checkOutput("ready_after_done", rdReady, 1);
      checkOutput("oe_after_done", lcdOe, 1);
    end
    validPrev = rdValid;
    if (rdValid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_valid", rdValid, 0);
      end else begin
        expHead = expQ.pop_front();
        checkOutput("rd_data", rdData, expHead.expData);
        checkOutput("busy", busy, expHead.expBusy);
        checkOutput("addr", addr, expHead.expAddr);
        checkOutput("timeout", timeout, expHead.expTo);
        checkOutput("en_pulses", pulses, expHead.expPulses);
        checkOutput("latency", cyc - acceptK, expHead.expLat);
        checkOutput("rw_in_done", lcdRw, 0);
      end
    end
  end

  task automatic applyStimulus(input vec_t v);
    int n;
    @(posedge clk); #1;
    n = 0;
    while (!rdReady && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("ready_before_req", rdReady, 1);
    curRs        = v.rs;
    curBusyReads = v.busyReads;
    curBusyByte  = v.busyByte;
    curFinal     = v.finalByte;
    rdRs   = v.rs;
    waitBf = v.wbf;
    rdReq  = 1'b1;
    expQ.push_back(v);
    @(posedge clk); #1;
    rdReq  = 1'b0;
    rdRs   = ~v.rs;
    waitBf = ~v.wbf;
    // Stray requests during EN high and during the last HOLD cycle must be dropped.
    if (v.stray) begin
      repeat (7) begin @(posedge clk); #1; end
      rdReq = 1'b1;
      @(posedge clk); #1;
      rdReq = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      rdReq = 1'b1;
      @(posedge clk); #1;
      rdReq = 1'b0;
    end
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("done_within_budget", expQ.size(), 0);
    expQ.delete();
    repeat (3) begin @(posedge clk); #1; end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n, extra;
    vecs[0] = '{1'b1, 1'b0, 0, 8'h00, 8'h41, 1'b1, 8'h41, 1'b1, 7'h00, 1'b0, 1, 20};
    vecs[1] = '{1'b0, 1'b0, 0, 8'h00, 8'h85, 1'b0, 8'h85, 1'b1, 7'h05, 1'b0, 1, 20};
    vecs[2] = '{1'b0, 1'b1, 3, 8'h80, 8'h12, 1'b0, 8'h12, 1'b0, 7'h12, 1'b0, 4, 152};
    vecs[3] = '{1'b1, 1'b1, 0, 8'h00, 8'hC3, 1'b0, 8'hC3, 1'b0, 7'h12, 1'b0, 1, 20};
    vecs[4] = '{1'b0, 1'b1, 8, 8'hFF, 8'hFF, 1'b0, 8'hFF, 1'b1, 7'h7F, 1'b1, 4, 152};
    vecs[5] = '{1'b1, 1'b0, 0, 8'h00, 8'h5A, 1'b0, 8'h5A, 1'b1, 7'h7F, 1'b1, 1, 20};
    vecs[6] = '{1'b0, 1'b0, 0, 8'h00, 8'h3C, 1'b0, 8'h3C, 1'b0, 7'h3C, 1'b0, 1, 20};
    vecs[7] = '{1'b0, 1'b1, 0, 8'h00, 8'h07, 1'b0, 8'h07, 1'b0, 7'h07, 1'b0, 1, 20};

    reset  = 1'b1;
    rdReq  = 1'b1;
    rdRs   = 1'b0;
    waitBf = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready", rdReady, 1);
    checkOutput("reset_valid", rdValid, 0);
    checkOutput("reset_en", lcdEn, 0);
    checkOutput("reset_rw", lcdRw, 0);
    checkOutput("reset_rs", lcdRs, 0);
    checkOutput("reset_oe", lcdOe, 1);
    checkOutput("reset_data", rdData, 8'h00);
    checkOutput("reset_busy", busy, 1);
    checkOutput("reset_addr", addr, 7'h00);
    checkOutput("reset_timeout", timeout, 0);
    reset = 1'b0;
    rdReq = 1'b0;
    @(posedge clk); #1;
    checkOutput("ready_after_reset", rdReady, 1);
    checkOutput("no_en_after_reset", lcdEn, 0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      waitDone();
    end

    // Reset in the middle of an EN pulse aborts with no rd_valid.
    inAbort = 1'b1;
    @(posedge clk); #1;
    rdRs   = 1'b1;
    waitBf = 1'b0;
    rdReq  = 1'b1;
    @(posedge clk); #1;
    rdReq = 1'b0;
    n = 0;
    while (!lcdEn && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("abort_en_reached", lcdEn, 1);
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("abort_en_still_high", lcdEn, 1);
    reset = 1'b1;
    rdReq = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_en", lcdEn, 0);
    checkOutput("abort_rw", lcdRw, 0);
    checkOutput("abort_rs", lcdRs, 0);
    checkOutput("abort_oe", lcdOe, 1);
    checkOutput("abort_ready", rdReady, 1);
    checkOutput("abort_valid", rdValid, 0);
    checkOutput("abort_data", rdData, 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    rdReq = 1'b0;
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (lcdEn || rdValid || !rdReady) extra++;
    end
    checkOutput("abort_quiet", extra, 0);
    inAbort = 1'b0;

    applyStimulus(vecs[0]);
    waitDone();

    checkOutput("protocol_violations", protoErr, 0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
